oam_dma_controller: RTL and testbench

//  Sequences the $4014 sprite (OAM) DMA on the CPU bus. Snoops CPU writes to $4014, then

---
 rtl/oam_dma_controller.sv | 143 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sprite (OAM) DMA sequencer for the 2A03 CPU bus.
// Snoops CPU writes to DMA_REG_ADDR, halts the CPU, then copies XFER_LEN bytes
// from page {data,8'h00} into PPU OAM as alternating read/write cycles.
// Optional build macro: OAM_DMA_ALIGN_EN inserts a parity-based ALIGN cycle so
// every DMA read lands on an even ("get") cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a CPU write to DMA_REG_ADDR
// HALT  | CPU frozen, bus owned, one dead cycle
// ALIGN | extra dead cycle so reads start on even parity (macro only)
// READ  | DMA_RDEN strobe, DMA_ADDR = {page, idx}
// WRITE | OAM_WREN strobe, OAM_WDATA = DMA_RDATA, advance idx
// DONE  | one-cycle DMA_DONE pulse, CPU released
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          XFER_LEN     = 256
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CPU_EN,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  output logic        CPU_HALT,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RDEN,
  input  logic [7:0]  DMA_RDATA,
  output logic        OAM_WREN,
  output logic [7:0]  OAM_ADDR,
  output logic [7:0]  OAM_WDATA,
  output logic        DMA_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] wdata_q;
  logic       trig;

  assign trig = CPU_EN & ~CPU_RW_n & (CPU_ADDR == DMA_REG_ADDR);

  // Read data only arrives in the WRITE cycle, so it is passed straight through
  // then and the captured copy holds the bus value between writes.
  assign OAM_WDATA = OAM_WREN ? DMA_RDATA : wdata_q;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running get/put parity, 0 on the first cycle after reset.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) parity <= 1'b0;
    else          parity <= ~parity;
  end
`endif

  // Transfer sequencer; every output is registered for the state being entered.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= S_IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      wdata_q    <= 8'h00;
      CPU_HALT   <= 1'b0;
      DMA_ACTIVE <= 1'b0;
      DMA_ADDR   <= 16'h0000;
      DMA_RDEN   <= 1'b0;
      OAM_WREN   <= 1'b0;
      OAM_ADDR   <= 8'h00;
      DMA_DONE   <= 1'b0;
    end else begin
      DMA_RDEN <= 1'b0;
      DMA_ADDR <= 16'h0000;
      OAM_WREN <= 1'b0;
      DMA_DONE <= 1'b0;
      case (state)
        // DONE accepts a trigger exactly like IDLE so back-to-back transfers
        // only release the CPU for the single DONE cycle.
        S_IDLE, S_DONE: begin
          if (trig) begin
            page       <= CPU_DATA_OUT;
            idx        <= 8'h00;
            CPU_HALT   <= 1'b1;
            DMA_ACTIVE <= 1'b1;
            state      <= S_HALT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (!parity) begin
            state <= S_ALIGN;
          end else
`endif
          begin
            DMA_RDEN <= 1'b1;
            DMA_ADDR <= {page, idx};
            state    <= S_READ;
          end
        end
        S_ALIGN: begin
          DMA_RDEN <= 1'b1;
          DMA_ADDR <= {page, idx};
          state    <= S_READ;
        end
        S_READ: begin
          OAM_WREN <= 1'b1;
          OAM_ADDR <= idx;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          wdata_q <= DMA_RDATA;
          if (idx == LAST_IDX) begin
            CPU_HALT   <= 1'b0;
            DMA_ACTIVE <= 1'b0;
            DMA_DONE   <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx      <= idx + 8'd1;
            DMA_RDEN <= 1'b1;
            DMA_ADDR <= {page, idx + 8'd1};
            state    <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: directed sequence of $4014 DMA transfers with random
// pages, memory contents and idle-bus traffic, checked against expected
// read/write streams and halt timing derived from the transfer rules.
module tb_oam_dma_controller;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        CPU_EN = 1'b0;
  logic [15:0] CPU_ADDR = 16'h0000;
  logic [7:0]  CPU_DATA_OUT = 8'h00;
  logic        CPU_RW_n = 1'b1;
  logic        CPU_HALT;
  logic        DMA_ACTIVE;
  logic [15:0] DMA_ADDR;
  logic        DMA_RDEN;
  logic [7:0]  DMA_RDATA = 8'h00;
  logic        OAM_WREN;
  logic [7:0]  OAM_ADDR;
  logic [7:0]  OAM_WDATA;
  logic        DMA_DONE;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [7:0]  seed = 8'h00;

  oam_dma_controller dut (
    .CLK(CLK), .RESET_n(RESET_n), .CPU_EN(CPU_EN), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n), .CPU_HALT(CPU_HALT),
    .DMA_ACTIVE(DMA_ACTIVE), .DMA_ADDR(DMA_ADDR), .DMA_RDEN(DMA_RDEN),
    .DMA_RDATA(DMA_RDATA), .OAM_WREN(OAM_WREN), .OAM_ADDR(OAM_ADDR),
    .OAM_WDATA(OAM_WDATA), .DMA_DONE(DMA_DONE)
  );

  always #5 CLK = ~CLK;

  // Cycles since reset release; bit 0 is the get/put parity of the current cycle.
  always @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd37;
    return lo ^ a[15:8] ^ seed;
  endfunction

  // Synchronous memory with one cycle of read latency.
  always @(posedge CLK) begin
    if (DMA_RDEN) DMA_RDATA <= mem_byte(DMA_ADDR);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    CPU_EN       = 1'b1;
    CPU_RW_n     = 1'($urandom_range(0, 1));
    CPU_ADDR     = 16'($urandom_range(0, 16'h3FFF));
    CPU_DATA_OUT = 8'($urandom);
  endtask

  task automatic drive_trig(input logic [7:0] d, input logic en);
    CPU_EN       = en;
    CPU_RW_n     = 1'b0;
    CPU_ADDR     = 16'h4014;
    CPU_DATA_OUT = d;
  endtask

  task automatic wait_parity(input int p);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      idle_bus();
      if (int'(cyc[0]) == p) break;
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'd0, CPU_HALT, DMA_ACTIVE, DMA_RDEN, OAM_WREN, DMA_DONE,
            DMA_ADDR, OAM_ADDR, OAM_WDATA};
  endfunction

  // Called at a negedge; the trigger write occupies the current cycle
  // (already driven when pre=1, e.g. coincident with a previous DONE).
  task automatic run_xfer(input string tag, input logic [7:0] page, input bit pre,
                          input int poke_idx, input int abort_idx,
                          input bit chain, input logic [7:0] chain_page);
    int exp_len, halt_cnt, rd_cnt, wr_cnt, bad_rd, bad_wr, bad_par, bad_zero;
    int bad_act, done_n, done_cnt, last_wr, gap_bad;
    exp_len = 513;
`ifdef OAM_DMA_ALIGN_EN
    if (((cyc + 1) % 2) == 0) exp_len = 514;
`endif
    halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; bad_rd = 0; bad_wr = 0; bad_par = 0;
    bad_zero = 0; bad_act = 0; done_n = 0; done_cnt = 0; last_wr = 0; gap_bad = 0;
    if (!pre) drive_trig(page, 1'b1);
    for (int n = 1; n <= 1100; n++) begin
      @(negedge CLK);
      idle_bus();
      if (n == 1) check({tag, "_halt_start"}, {62'd0, CPU_HALT, DMA_ACTIVE}, 64'd3);
      if (CPU_HALT) halt_cnt++;
      if (CPU_HALT !== DMA_ACTIVE) bad_act++;
      if (DMA_RDEN) begin
        if (DMA_ADDR !== {page, 8'(rd_cnt)}) bad_rd++;
`ifdef OAM_DMA_ALIGN_EN
        if (cyc[0]) bad_par++;
`endif
        if (rd_cnt == abort_idx) begin
          #1 RESET_n = 1'b0;
          #1 check({tag, "_abort_outputs"}, all_outputs(), 64'd0);
          done_cnt = 0;
          for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (DMA_DONE || CPU_HALT || DMA_RDEN) done_cnt++;
          end
          check({tag, "_abort_quiet"}, 64'(done_cnt), 64'd0);
          RESET_n = 1'b1;
          return;
        end
        rd_cnt++;
      end else if (DMA_ADDR !== 16'h0000) begin
        bad_zero++;
      end
      if (OAM_WREN) begin
        if (OAM_ADDR !== 8'(wr_cnt) || OAM_WDATA !== mem_byte({page, 8'(wr_cnt)})) bad_wr++;
        if (wr_cnt == poke_idx) drive_trig(8'h05, 1'b1);
        wr_cnt++;
        last_wr = n;
      end
      if (DMA_DONE) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
        if (CPU_HALT || DMA_ACTIVE) gap_bad++;
        if (chain) begin
          drive_trig(chain_page, 1'b1);
          break;
        end
      end
      if (done_n != 0 && n >= done_n + 3) break;
    end
    check({tag, "_reads"},      64'(rd_cnt),   64'd256);
    check({tag, "_read_addr"},  64'(bad_rd),   64'd0);
    check({tag, "_writes"},     64'(wr_cnt),   64'd256);
    check({tag, "_oam_data"},   64'(bad_wr),   64'd0);
    check({tag, "_addr_zero"},  64'(bad_zero), 64'd0);
    check({tag, "_halt_len"},   64'(halt_cnt), 64'(exp_len));
    check({tag, "_active_eq"},  64'(bad_act),  64'd0);
    check({tag, "_last_write"}, 64'(last_wr),  64'(exp_len));
    check({tag, "_done_time"},  64'(done_n),   64'(exp_len + 1));
    check({tag, "_done_once"},  64'(done_cnt), 64'd1);
    check({tag, "_done_free"},  64'(gap_bad),  64'd0);
    check({tag, "_rd_parity"},  64'(bad_par),  64'd0);
  endtask

  initial begin
    int cnt;
    seed = 8'($urandom);
    repeat (2) @(negedge CLK);
    check("reset_outputs", all_outputs(), 64'd0);
    RESET_n = 1'b1;
    idle_bus();
    repeat ($urandom_range(2, 6)) begin @(negedge CLK); idle_bus(); end
    check("idle_outputs", all_outputs(), 64'd0);

    wait_parity(1);
    run_xfer("odd_p02", 8'h02, 1'b0, -1, -1, 1'b0, 8'h00);

    wait_parity(0);
    run_xfer("even_rand", 8'($urandom), 1'b0, -1, -1, 1'b0, 8'h00);

    @(negedge CLK);
    drive_trig(8'h07, 1'b0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      idle_bus();
      if (CPU_HALT || DMA_ACTIVE || DMA_RDEN) cnt++;
    end
    check("cpu_en_low", 64'(cnt), 64'd0);

    repeat ($urandom_range(1, 4)) begin @(negedge CLK); idle_bus(); end
    run_xfer("ignore_mid", 8'h03, 1'b0, 8'h40, -1, 1'b0, 8'h00);

    repeat ($urandom_range(1, 4)) begin @(negedge CLK); idle_bus(); end
    run_xfer("abort", 8'($urandom), 1'b0, -1, 8'h80, 1'b0, 8'h00);
    repeat ($urandom_range(1, 3)) begin @(negedge CLK); idle_bus(); end
    check("post_abort_idle", all_outputs(), 64'd0);
    run_xfer("after_abort", 8'($urandom), 1'b0, -1, -1, 1'b0, 8'h00);

    repeat ($urandom_range(1, 4)) begin @(negedge CLK); idle_bus(); end
    run_xfer("chain_a", 8'h11, 1'b0, -1, -1, 1'b1, 8'h2C);
    run_xfer("chain_b", 8'h2C, 1'b1, -1, -1, 1'b0, 8'h00);

    repeat ($urandom_range(1, 4)) begin @(negedge CLK); idle_bus(); end
    run_xfer("page_ff", 8'hFF, 1'b0, -1, -1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
